// File: rtl/instr_prefetch_buffer_pkg.sv
// Shared types for the instruction prefetch front end.
package instr_prefetch_buffer_pkg;

  localparam logic [31:0] FETCH_WORD_BYTES = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    STALE_REQ
  } fetch_state_e;

endpackage

// File: rtl/instr_prefetch_buffer_if.sv
// OBI-style instruction port plus the decoder-facing valid/ready port.
interface instr_prefetch_buffer_if;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i;
  logic [31:0] instr_rdata_i;
  logic        instr_rvalid_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_instr_o;
  logic [31:0] out_pc_o;

  modport master (
    output instr_req_o, instr_addr_o, out_valid_o, out_instr_o, out_pc_o,
    input  instr_gnt_i, instr_rdata_i, instr_rvalid_i, out_ready_i
  );

  modport slave (
    input  instr_req_o, instr_addr_o, out_valid_o, out_instr_o, out_pc_o,
    output instr_gnt_i, instr_rdata_i, instr_rvalid_i, out_ready_i
  );
endinterface

// File: rtl/instr_prefetch_buffer_fifo.sv
// Synchronous FIFO with registered storage, occupancy count and synchronous clear.
module instr_prefetch_buffer_fifo
  import instr_prefetch_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = fetch_entry_t
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  T                           wdata_i,
  input  logic                       pop_i,
  output T                           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] cnt_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  T              mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = mem_q[rd_ptr_q];
  assign cnt_o   = cnt_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/instr_prefetch_buffer.sv
// Instruction fetch front end: sequential OBI word fetches, outstanding-response
// tracking with flush discard, and a {pc, instr} queue towards the decoder.
module instr_prefetch_buffer
  import instr_prefetch_buffer_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0080
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    fetch_en_i,
  input  logic                    flush_i,
  input  logic [31:0]             flush_addr_i,
  instr_prefetch_buffer_if.master bus
);
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned SW = CW + 1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   addr_q, addr_d, tgt_q, tgt_d, resp_pc_q, flush_tgt;
  logic [CW-1:0] inflight_q, discard_q, fifo_cnt;
  logic [SW-1:0] occ;
  logic          gnt_fire, stale_gnt, rsp_ok, rsp_drop, push, pop, issue;
  logic          fifo_empty, fifo_full, unused_lsb;
  fetch_entry_t  wentry, rentry;

  assign flush_tgt  = {flush_addr_i[31:2], 2'b00};
  assign unused_lsb = ^flush_addr_i[1:0];
  assign gnt_fire   = bus.instr_req_o & bus.instr_gnt_i;
  assign stale_gnt  = gnt_fire & (state_q == STALE_REQ);
  assign rsp_ok     = bus.instr_rvalid_i & (inflight_q != '0);
  assign rsp_drop   = rsp_ok & (discard_q != '0);
  assign push       = rsp_ok & ~rsp_drop & ~flush_i;
  assign pop        = bus.out_valid_o & bus.out_ready_i;
  assign wentry     = '{pc: resp_pc_q, instr: bus.instr_rdata_i};

  // Occupancy counts this cycle's grant so a back-to-back request never overcommits.
  assign occ   = SW'(fifo_cnt) + SW'(inflight_q) + SW'(gnt_fire);
  assign issue = fetch_en_i & (occ < SW'(DEPTH));

  assign bus.instr_req_o  = (state_q != IDLE);
  assign bus.instr_addr_o = addr_q;
  assign bus.out_valid_o  = ~fifo_empty & ~flush_i;
  assign bus.out_instr_o  = rentry.instr;
  assign bus.out_pc_o     = rentry.pc;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    tgt_d   = tgt_q;
    unique case (state_q)
      IDLE: begin
        if (flush_i)    addr_d  = flush_tgt;
        else if (issue) state_d = REQ;
      end
      REQ, STALE_REQ: begin
        if (flush_i) begin
          if (gnt_fire) begin
            state_d = IDLE;
            addr_d  = flush_tgt;
          end else begin
            // Address must hold until granted; the redirect waits in tgt_q.
            state_d = STALE_REQ;
            tgt_d   = flush_tgt;
          end
        end else if (gnt_fire) begin
          addr_d  = (state_q == STALE_REQ) ? tgt_q : addr_q + FETCH_WORD_BYTES;
          state_d = issue ? REQ : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      addr_q     <= BOOT_ADDR;
      tgt_q      <= BOOT_ADDR;
      resp_pc_q  <= BOOT_ADDR;
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      tgt_q      <= tgt_d;
      inflight_q <= inflight_q + CW'(gnt_fire) - CW'(rsp_ok);
      if (flush_i) begin
        discard_q <= inflight_q + CW'(gnt_fire) - CW'(rsp_ok);
        resp_pc_q <= flush_tgt;
      end else begin
        discard_q <= discard_q + CW'(stale_gnt) - CW'(rsp_drop);
        if (push) resp_pc_q <= resp_pc_q + FETCH_WORD_BYTES;
      end
    end
  end

  instr_prefetch_buffer_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (flush_i),
    .push_i  (push),
    .wdata_i (wentry),
    .pop_i   (pop),
    .rdata_o (rentry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .cnt_o   (fifo_cnt)
  );

  rvalid_without_request: assert property (@(posedge clk_i) disable iff (!rst_ni)
    bus.instr_rvalid_i |-> inflight_q != '0);
  push_into_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    push |-> !fifo_full || pop);
endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Directed bench: in-order OBI memory model, decoder-side monitor, table of redirects.
module tb_instr_prefetch_buffer;
  import instr_prefetch_buffer_pkg::*;

  typedef struct {
    logic [31:0] fa;
    logic [31:0] pc0;
    logic [31:0] pc_last;
    bit          slow;
  } vec_t;

  logic        clk_i = 1'b0, rst_ni = 1'b0, fetch_en_i = 1'b0, flush_i = 1'b0;
  logic [31:0] flush_addr_i = '0;
  instr_prefetch_buffer_if bus();

  instr_prefetch_buffer #(.DEPTH(4), .BOOT_ADDR(32'h0000_0080)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .fetch_en_i   (fetch_en_i),
    .flush_i      (flush_i),
    .flush_addr_i (flush_addr_i),
    .bus          (bus)
  );

  initial forever #5 clk_i = ~clk_i;

  int n_vec = 0, n_err = 0;
  logic [31:0] q_addr[$];
  int          q_t[$];
  logic [31:0] gnt_log[$];
  fetch_entry_t got[$];
  int  cyc = 0, n_gnt = 0, grant_cap = 1000000, rsp_lat = 1, cnt_rsp = 0, cnt_pop = 0;
  int  occ, max_occ = 0;
  bit  rsp_hold = 0, slow = 0;
  vec_t vecs[5];

  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'h11 * (((a - 32'h80) >> 2) + 32'd1);
  endfunction

  // Memory: in-order responses no earlier than rsp_lat cycles after the grant.
  initial begin
    bus.instr_gnt_i = 1'b0; bus.instr_rvalid_i = 1'b0; bus.instr_rdata_i = '0;
    forever begin
      @(negedge clk_i); #2;
      cyc++;
      if (!rst_ni) begin
        q_addr.delete(); q_t.delete();
        bus.instr_gnt_i = 1'b0; bus.instr_rvalid_i = 1'b0;
        continue;
      end
      bus.instr_rvalid_i = 1'b0;
      if (q_addr.size() > 0 && !rsp_hold && (cyc - q_t[0]) >= rsp_lat) begin
        bus.instr_rvalid_i = 1'b1;
        bus.instr_rdata_i  = mem(q_addr[0]);
        void'(q_addr.pop_front()); void'(q_t.pop_front());
        cnt_rsp++;
      end
      bus.instr_gnt_i = bus.instr_req_o && (n_gnt < grant_cap) && (!slow || (cyc % 2 == 1));
      if (bus.instr_gnt_i) begin
        q_addr.push_back(bus.instr_addr_o); q_t.push_back(cyc);
        gnt_log.push_back(bus.instr_addr_o); n_gnt++;
      end
    end
  end

  // Decoder side: record every accepted entry, track fifo + in-flight occupancy.
  initial forever begin
    @(negedge clk_i); #4;
    if (rst_ni) begin
      if (bus.out_valid_o && bus.out_ready_i) begin
        got.push_back('{pc: bus.out_pc_o, instr: bus.out_instr_o});
        cnt_pop++;
      end
      occ = q_addr.size() + cnt_rsp - cnt_pop;
      if (occ > max_occ) max_occ = occ;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wait_got(input int n, input int budget);
    int c = 0;
    while (got.size() < n && c < budget) begin @(negedge clk_i); c++; end
    if (got.size() < n) begin
      n_vec++; n_err++;
      $display("FAIL timeout: %0d entries received, %0d required", got.size(), n);
      while (got.size() < n) got.push_back('{pc: '1, instr: '1});
    end
  endtask

  task automatic chk_seq(input string name, input logic [31:0] pc0, input int n);
    wait_got(n, 200);
    for (int k = 0; k < n; k++) begin
      chk({name, " pc"},    got[k].pc,    pc0 + 32'(4 * k));
      chk({name, " instr"}, got[k].instr, mem(pc0 + 32'(4 * k)));
    end
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0; flush_i = 1'b0;
    got.delete(); gnt_log.delete();
    n_gnt = 0; cnt_rsp = 0; cnt_pop = 0; max_occ = 0;
    #1;
    chk("rst req",   32'(bus.instr_req_o), 32'd0);
    chk("rst addr",  bus.instr_addr_o,     32'h80);
    chk("rst valid", 32'(bus.out_valid_o), 32'd0);
    chk("rst instr", bus.out_instr_o,      32'd0);
    chk("rst pc",    bus.out_pc_o,         32'd0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic do_flush(input logic [31:0] a);
    @(negedge clk_i);
    flush_i = 1'b1; flush_addr_i = a; got.delete();
    #4 chk("valid in flush cycle", 32'(bus.out_valid_o), 32'd0);
    @(negedge clk_i);
    flush_i = 1'b0;
  endtask

  initial begin
    logic [31:0] last_pc;
    int c;
    vecs[0] = '{32'h0000_0200, 32'h0000_0200, 32'h0000_020C, 1'b0};
    vecs[1] = '{32'h0000_0203, 32'h0000_0200, 32'h0000_020C, 1'b1};
    vecs[2] = '{32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'h0000_0004, 1'b0};
    vecs[3] = '{32'h0000_1001, 32'h0000_1000, 32'h0000_100C, 1'b1};
    vecs[4] = '{32'h0000_0040, 32'h0000_0040, 32'h0000_004C, 1'b0};
    bus.out_ready_i = 1'b0;

    // Boot fetch, in-order delivery
    do_reset();
    fetch_en_i = 1'b1; bus.out_ready_i = 1'b1;
    chk_seq("boot", 32'h80, 6);

    // Decoder stall: occupancy caps at DEPTH, then contiguous continuation
    @(negedge clk_i);
    bus.out_ready_i = 1'b0;
    last_pc = got[got.size() - 1].pc;
    got.delete(); max_occ = 0;
    repeat (20) @(negedge clk_i);
    chk("stall max occupancy", 32'(max_occ), 32'd4);
    chk("stall req idle", 32'(bus.instr_req_o), 32'd0);
    bus.out_ready_i = 1'b1;
    chk_seq("stall resume", last_pc + 32'd4, 6);

    // Flush with two responses outstanding and a request pending
    do_reset();
    rsp_hold = 1'b1; grant_cap = 2;
    c = 0;
    while (q_addr.size() < 2 && c < 50) begin @(negedge clk_i); c++; end
    chk("two in flight", 32'(q_addr.size()), 32'd2);
    do_flush(32'h200);
    rsp_hold = 1'b0; grant_cap = 1000000;
    chk_seq("inflight flush", 32'h200, 4);
    chk("stale grant addr", gnt_log[2], 32'h88);
    chk("redirect grant addr", gnt_log[3], 32'h200);

    // Flush while a request at 0x90 is waiting for grant
    do_reset();
    grant_cap = 4;
    c = 0;
    while (!(n_gnt == 4 && bus.instr_req_o && bus.instr_addr_o == 32'h90) && c < 60) begin
      @(negedge clk_i); c++;
    end
    chk("pending addr", bus.instr_addr_o, 32'h90);
    fetch_en_i = 1'b0;
    repeat (6) @(negedge clk_i);
    chk("pending req holds", 32'(bus.instr_req_o), 32'd1);
    fetch_en_i = 1'b1;
    chk_seq("pre flush", 32'h80, 4);
    do_flush(32'h200);
    repeat (3) @(negedge clk_i);
    chk("stale req holds", 32'(bus.instr_req_o), 32'd1);
    chk("stale addr holds", bus.instr_addr_o, 32'h90);
    grant_cap = 1000000;
    chk_seq("stale flush", 32'h200, 3);
    chk("stale grant 0x90", gnt_log[4], 32'h90);
    chk("next grant 0x200", gnt_log[5], 32'h200);

    // Redirect table: alignment, wrap, slow grants, in-flight responses
    do_reset();
    rsp_lat = 2;
    for (int v = 0; v < 5; v++) begin
      slow = vecs[v].slow;
      repeat (3) @(negedge clk_i);
      do_flush(vecs[v].fa);
      chk_seq($sformatf("vec%0d", v), vecs[v].pc0, 4);
      chk($sformatf("vec%0d last pc", v), got[3].pc, vecs[v].pc_last);
    end

    // Reset with a full queue and traffic in flight
    slow = 1'b0; rsp_lat = 1;
    bus.out_ready_i = 1'b0;
    repeat (15) @(negedge clk_i);
    chk("queue filled", 32'(bus.out_valid_o), 32'd1);
    do_reset();
    bus.out_ready_i = 1'b1;
    chk_seq("after reset", 32'h80, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
